// File: rtl/fjmem_core.sv
// fjmem_core: bridges a JTAG BSCAN user data register to a parallel NOR flash bus.
// Optional build macro FJMEM_TCK_FILTER_EN adds a 3-sample majority filter on synced TCK.
module fjmem_core #(
  parameter int unsigned ADR_W   = 24,
  parameter int unsigned DAT_W   = 16,
  parameter int unsigned RD_WAIT = 8,
  parameter int unsigned WR_WAIT = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             jtag_tck,
  input  logic             jtag_rst,
  input  logic             jtag_update,
  input  logic             jtag_shift,
  input  logic             jtag_tdi,
  output logic             jtag_tdo,
  output logic [ADR_W-1:0] flash_adr,
  output logic [DAT_W-1:0] flash_d_o,
  input  logic [DAT_W-1:0] flash_d_i,
  output logic             flash_d_oe,
  output logic             flash_ce_n,
  output logic             flash_oe_n,
  output logic             flash_we_n
);

  localparam int unsigned DR_W     = 3 + ADR_W + DAT_W;
  localparam int unsigned ADR_LSB  = 3;
  localparam int unsigned DAT_LSB  = 3 + ADR_W;
  localparam int unsigned MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT) + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WSETUP = 3'd2,
    ST_WRITE  = 3'd3,
    ST_WHOLD  = 3'd4
  } state_e;

  // 2-FF synchronizers; bit order {tdi, shift, update, rst, tck}
  logic [4:0] jtag_in;
  logic [4:0] meta_q, sync_q;

  assign jtag_in = {jtag_tdi, jtag_shift, jtag_update, jtag_rst, jtag_tck};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= jtag_in;
      sync_q <= meta_q;
    end
  end

  logic tck_lvl, tdi_lvl, shift_lvl, rst_lvl, upd_lvl;
  assign rst_lvl = sync_q[1];
  assign upd_lvl = sync_q[2];

`ifdef FJMEM_TCK_FILTER_EN
  // Majority of three TCK samples; tdi/shift delayed to stay aligned with it
  logic [1:0] tck_hist_q, tdi_dly_q, shift_dly_q;
  logic       tck_filt_q;
  logic       tck_maj;

  assign tck_maj = (sync_q[0] & tck_hist_q[0]) | (sync_q[0] & tck_hist_q[1]) |
                   (tck_hist_q[0] & tck_hist_q[1]);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tck_hist_q  <= '0;
      tdi_dly_q   <= '0;
      shift_dly_q <= '0;
      tck_filt_q  <= 1'b0;
    end else begin
      tck_hist_q  <= {tck_hist_q[0], sync_q[0]};
      tdi_dly_q   <= {tdi_dly_q[0], sync_q[4]};
      shift_dly_q <= {shift_dly_q[0], sync_q[3]};
      tck_filt_q  <= tck_maj;
    end
  end

  assign tck_lvl   = tck_filt_q;
  assign tdi_lvl   = tdi_dly_q[1];
  assign shift_lvl = shift_dly_q[1];
`else
  assign tck_lvl   = sync_q[0];
  assign tdi_lvl   = sync_q[4];
  assign shift_lvl = sync_q[3];
`endif

  logic tck_prev_q, upd_prev_q;
  logic tck_rise, upd_rise;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tck_prev_q <= 1'b0;
      upd_prev_q <= 1'b0;
    end else begin
      tck_prev_q <= tck_lvl;
      upd_prev_q <= upd_lvl;
    end
  end

  assign tck_rise = tck_lvl & ~tck_prev_q;
  assign upd_rise = upd_lvl & ~upd_prev_q;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DR_W-1:0]   dr_q, dr_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DAT_W-1:0]  dat_q, dat_d;
  logic              abort_q, abort_d;
  logic              tdo_q;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, d_oe_q, d_oe_d;
  logic              upd_accept, load_rd, load_wr, last_wait;

  assign upd_accept = upd_rise & ~rst_lvl & (state_q == ST_IDLE);
  assign last_wait  = (cnt_q == CNT_W'(1));
  assign load_rd    = (state_q == ST_READ) & last_wait & ~abort_q;
  assign load_wr    = (state_q == ST_WHOLD) & ~abort_q;

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (upd_accept) begin
          if (dr_q[2]) begin
            state_d = ST_WSETUP;
          end else if (dr_q[1]) begin
            state_d = ST_READ;
            cnt_d   = CNT_W'(RD_WAIT);
          end
        end
      end
      ST_READ: begin
        if (last_wait) state_d = ST_IDLE;
        else           cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_WSETUP: begin
        state_d = ST_WRITE;
        cnt_d   = CNT_W'(WR_WAIT);
      end
      ST_WRITE: begin
        if (last_wait) state_d = ST_WHOLD;
        else           cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_WHOLD: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so the registered pins track the state
  always_comb begin
    ce_n_d = 1'b1;
    oe_n_d = 1'b1;
    we_n_d = 1'b1;
    d_oe_d = 1'b0;
    case (state_d)
      ST_READ: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      ST_WSETUP, ST_WHOLD: begin
        ce_n_d = 1'b0;
        d_oe_d = 1'b1;
      end
      ST_WRITE: begin
        ce_n_d = 1'b0;
        we_n_d = 1'b0;
        d_oe_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Data register: jtag reset beats result load beats update clear beats shift
  always_comb begin
    dr_d    = dr_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    abort_d = abort_q | (rst_lvl & (state_q != ST_IDLE));
    if (upd_accept) begin
      adr_d   = dr_q[ADR_LSB +: ADR_W];
      dat_d   = dr_q[DAT_LSB +: DAT_W];
      abort_d = 1'b0;
    end
    if (rst_lvl) begin
      dr_d = '0;
    end else if (load_rd) begin
      dr_d[DAT_LSB +: DAT_W] = flash_d_i;
      dr_d[0]                = 1'b1;
    end else if (load_wr) begin
      dr_d[0] = 1'b1;
    end else if (upd_accept) begin
      dr_d[0] = 1'b0;
    end else if (tck_rise && shift_lvl) begin
      dr_d = {tdi_lvl, dr_q[DR_W-1:1]};
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q   <= '0;
      dr_q    <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      abort_q <= 1'b0;
      tdo_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      d_oe_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dr_q    <= dr_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      abort_q <= abort_d;
      tdo_q   <= dr_q[0];
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      d_oe_q  <= d_oe_d;
    end
  end

  assign jtag_tdo   = tdo_q;
  assign flash_adr  = adr_q;
  assign flash_d_o  = dat_q;
  assign flash_d_oe = d_oe_q;
  assign flash_ce_n = ce_n_q;
  assign flash_oe_n = oe_n_q;
  assign flash_we_n = we_n_q;

endmodule

// File: doc/fjmem_core.md
Name: fjmem_core

Overview:
- Downstream consumer of the JTAG BSCAN wrapper's user-chain signals (DRCK/TCK, RESET, UPDATE, SHIFT, TDI, TDO); bridges them to a parallel NOR flash bus.
- Oversamples the JTAG signals in sys_clk and implements a user data register (DR) shifted LSB-first.
- On Update-DR, performs one flash read or write with programmable wait states.
- Loads read data and an ack bit back into the DR, so the host gets the result on its next DR scan.

Parameters:
- ADR_W, 24, flash word-address width
- DAT_W, 16, flash data width
- RD_WAIT, 8, sys_clk cycles oe_n is held low per read (min 1)
- WR_WAIT, 8, sys_clk cycles we_n is held low per write (min 1)

Ports:
- sys_clk  in  1  system clock; all logic is clocked on its rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- jtag_tck  in  1  JTAG DR shift clock from the BSCAN wrapper (async to sys_clk)
- jtag_rst  in  1  TAP Test-Logic-Reset indication (async)
- jtag_update  in  1  Update-DR level (async)
- jtag_shift  in  1  Shift-DR level (async)
- jtag_tdi  in  1  serial data in (async)
- jtag_tdo  out  1  serial data out, registered
- flash_adr  out  ADR_W  flash address
- flash_d_o  out  DAT_W  write data
- flash_d_i  in  DAT_W  read data
- flash_d_oe  out  1  data bus output enable for the top-level tristate
- flash_ce_n  out  1  chip enable, active low
- flash_oe_n  out  1  output enable, active low
- flash_we_n  out  1  write enable, active low

Behaviour:
- Reset (sys_rst_n=0, asynchronous):
  - flash_ce_n=1, flash_oe_n=1, flash_we_n=1, flash_d_oe=0
  - flash_adr=0, flash_d_o=0, jtag_tdo=0
  - DR=0, FSM=IDLE, all synchronizers=0
  - Any flash cycle in progress is aborted immediately.
- Synchronization:
  - Each jtag_* input passes through a 2-FF synchronizer, then one edge-detect register.
  - sys_clk must be at least 4x jtag_tck.
- TCK rising edge (detected) with shift=1:
  - DR <= {tdi, DR[N-1:1]}, where N = 3+ADR_W+DAT_W (43 at defaults).
  - jtag_tdo is updated to DR[0] every sys_clk cycle.
- DR layout:
  - bit0 ack, bit1 re, bit2 we
  - [3 +: ADR_W] addr
  - [3+ADR_W +: DAT_W] data
- Rising edge of synced update, FSM=IDLE:
  - Latch addr/data/re/we from the DR and clear DR[0].
  - we=1 -> WSETUP; re=1 only -> READ; neither -> stay IDLE.
  - we has priority when both re and we are set.
- Rising edge of update while FSM busy: ignored, with no side effects.
- READ:
  - ce_n=0, oe_n=0, adr driven, d_oe=0, for exactly RD_WAIT cycles.
  - On the last cycle, DR data field <= flash_d_i and DR[0] <= 1.
  - Next state IDLE; ce_n and oe_n return to 1.
- WSETUP: 1 cycle; ce_n=0, d_oe=1, adr/d_o driven, we_n=1.
- WRITE: we_n=0 for exactly WR_WAIT cycles; ce_n, d_oe, adr and d_o held.
- WHOLD:
  - 1 cycle with we_n=1, ce_n=0, d_oe=1.
  - Then IDLE, DR[0] <= 1, and ce_n=1, d_oe=0.
- Wait counter: width $clog2(max(RD_WAIT,WR_WAIT))+1, loaded on state entry, counts down to 1.
- Result load and shift edge in the same cycle: the load wins and that shift is dropped.
  - The host protocol waits ≥ RD_WAIT+WR_WAIT+12 sys_clk after Update-DR before scanning.
- jtag_rst (synced, level=1):
  - DR is cleared synchronously.
  - An in-progress flash cycle runs to completion, but its result/ack is not loaded into the DR.
  - Update edges are ignored while jtag_rst is high.
- Address and data outputs hold their last values in IDLE; only strobes and d_oe return to inactive.

Optional Feature:
- Macro FJMEM_TCK_FILTER_EN.
- Defined: synced TCK passes through a 3-sample majority filter before edge detection.
  - Adds 2 cycles of latency.
  - Single-cycle TCK glitches produce no shift.
  - sys_clk must then be at least 8x TCK.
- Undefined: no filter; a single-cycle TCK pulse that survives synchronization causes one shift.

Test Plan:
- Reset: assert sys_rst_n=0 mid-WRITE (we_n=0) -> we_n, ce_n, oe_n=1, d_oe=0 and tdo=0 in the same cycle, before any clock edge.
- Read: shift 43 bits with addr=0x000123, re=1, we=0; pulse update; flash model returns 0xBEEF -> oe_n low for exactly 8 cycles. Next 43-bit scan returns bit0=1 and data field 0xBEEF on TDO.
- Write: addr=0x00FFFF, data=0x5A5A, we=1 -> WSETUP 1 cycle, we_n low 8 cycles, WHOLD 1 cycle, d_oe high for all 10. Flash model captures 0x5A5A@0x00FFFF; next scan shows ack=1.
- Priority/busy: re=we=1 -> write only, no oe_n pulse. Second update pulse during WRITE -> ignored, exactly one write observed.
- jtag_rst during READ -> read completes on the bus; the following scan shows DR all zeros, ack=0.
- With FJMEM_TCK_FILTER_EN: inject one-sys_clk TCK glitches during shift -> DR unchanged. Without the macro -> DR shifts by one per surviving glitch.
